// File: rtl/store_buffer.sv
// Posted-write store buffer between the memory stage and data_memory.
// Define STBUF_FORWARD_EN to forward buffered data to matching loads instead of stalling.
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              MemWrite,
    input  logic              MemRead,
    output logic [DATA_W-1:0] ReadData,
    output logic              Stall,
    output logic              Empty,
    output logic [ADDR_W-1:0] MemAddress,
    output logic [DATA_W-1:0] MemWriteData,
    output logic              MemWriteEn,
    input  logic [DATA_W-1:0] MemReadData
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WA_W  = ADDR_W - 2;

    logic [WA_W-1:0]   waddr_q [DEPTH];
    logic [DATA_W-1:0] data_q  [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;

    logic              full;
    logic              idle;
    logic              hit;
    logic              push;
    logic              drain;
    logic [WA_W-1:0]   word;
    logic [PTR_W-1:0]  idx;

    assign word  = Address[ADDR_W-1:2];
    assign full  = (count == CNT_W'(DEPTH));
    assign Empty = (count == '0);
    assign idle  = ~MemRead & ~MemWrite;

`ifdef STBUF_FORWARD_EN
    logic [DATA_W-1:0] hit_data;

    // Scan oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (waddr_q[idx] == word)) begin
                hit      = 1'b1;
                hit_data = data_q[idx];
            end
        end
    end

    assign Stall    = MemWrite & full;
    assign ReadData = hit ? hit_data : MemReadData;
`else
    logic load;

    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (waddr_q[idx] == word)) begin
                hit = 1'b1;
            end
        end
    end

    // A load that hits a pending store waits until that store reaches memory.
    assign load     = MemRead & ~MemWrite;
    assign Stall    = (MemWrite & full) | (load & hit);
    assign ReadData = MemReadData;
`endif

    // Reset suppresses the memory write as well as the pop.
    assign drain = ~Reset & ~Empty & (idle | Stall);
    assign push  = ~Reset & MemWrite & ~full;

    assign MemWriteEn   = drain;
    assign MemAddress   = drain ? {waddr_q[head], 2'b00} : Address;
    assign MemWriteData = data_q[head];

    // Control state: pointers and occupancy.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (push) begin
            tail  <= tail + PTR_W'(1);
            count <= count + CNT_W'(1);
        end else if (drain) begin
            head  <= head + PTR_W'(1);
            count <= count - CNT_W'(1);
        end
    end

    // Entry storage, written only on accepted stores.
    always_ff @(posedge CLK) begin
        if (push) begin
            waddr_q[tail] <= word;
            data_q[tail]  <= WriteData;
        end
    end

endmodule
